issue_unit: RTL and testbench

ISSUE_UNIT -- requirements
Module: issue_unit

---
 rtl/issue_if.sv | 47 ++++
 rtl/issue_unit.sv | 179 +++++++++++++++++
 tb/tb_issue_unit.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_if.sv
// Issue unit signal bundle: decoded-instruction input, reservation-station
// dispatch/acknowledge, common data bus and the stall counter.
interface issue_if;
  logic        in_instr_valid;
  logic [5:0]  in_operator_type;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic        in_use_imm;
  logic [31:0] in_imm;
  logic        out_instr_ready;

  logic        out_rs_enable;
  logic [5:0]  out_operator_type;
  logic [31:0] out_val_1;
  logic [31:0] out_val_2;
  logic [4:0]  out_tag_1;
  logic [4:0]  out_tag_2;
  logic [3:0]  out_ICC_flags;
  logic        in_rs_ack;
  logic [4:0]  in_rs_tag;

  logic        in_CDB_broadcast;
  logic [4:0]  in_CDB_tag;
  logic [31:0] in_CDB_val;
  logic [3:0]  in_CDB_ICC_flags;

  logic [15:0] out_stall_cycles;

  modport slave (
    input  in_instr_valid, in_operator_type, in_rs1, in_rs2, in_rd,
           in_use_imm, in_imm, in_rs_ack, in_rs_tag,
           in_CDB_broadcast, in_CDB_tag, in_CDB_val, in_CDB_ICC_flags,
    output out_instr_ready, out_rs_enable, out_operator_type,
           out_val_1, out_val_2, out_tag_1, out_tag_2, out_ICC_flags,
           out_stall_cycles
  );

  modport master (
    output in_instr_valid, in_operator_type, in_rs1, in_rs2, in_rd,
           in_use_imm, in_imm, in_rs_ack, in_rs_tag,
           in_CDB_broadcast, in_CDB_tag, in_CDB_val, in_CDB_ICC_flags,
    input  out_instr_ready, out_rs_enable, out_operator_type,
           out_val_1, out_val_2, out_tag_1, out_tag_2, out_ICC_flags,
           out_stall_cycles
  );
endinterface

// File: rtl/issue_unit.sv
// Tomasulo-style issue stage: renamed register file + ICC, operand capture with
// CDB bypass, single-entry dispatch to the reservation station.
//   state    | meaning
//   IDLE     | ready for an instruction; capture or hold on carry stall
//   SEND     | one-cycle dispatch strobe to the reservation station
//   WAIT_ACK | hold dispatch fields until the station acknowledges
module issue_unit #(
  parameter logic [4:0] INVALID_TAG = 5'b11111
) (
  input logic    clk,
  input logic    rst,
  issue_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t      state_q, state_d;

  logic [31:0] rf_val_q [32];
  logic [4:0]  rf_tag_q [32];
  logic [3:0]  icc_val_q;
  logic [4:0]  icc_tag_q;

  logic [5:0]  op_q;
  logic [31:0] val1_q, val2_q;
  logic [4:0]  tag1_q, tag2_q;
  logic [3:0]  flags_q;
  logic [4:0]  rd_q;
  logic [15:0] stall_q, stall_d;

  logic        cdb_en;
  logic [31:0] src1_val, src2_val, cap_val1, cap_val2;
  logic [4:0]  src1_tag, src2_tag, cap_tag1, cap_tag2;
  logic        hit1, hit2;
  logic        icc_hit, icc_ready;
  logic [3:0]  cap_flags;
  logic        carry_stall, capture, ack_fire, icc_rename;
  logic [31:0] ren_hit, wb_hit;

  // A broadcast carrying the "ready" tag matches nothing.
  assign cdb_en = bus.in_CDB_broadcast && (bus.in_CDB_tag != INVALID_TAG);

  always_comb begin
    src1_val = '0;
    src1_tag = INVALID_TAG;
    src2_val = '0;
    src2_tag = INVALID_TAG;
    if (bus.in_rs1 != 5'd0) begin
      src1_val = rf_val_q[bus.in_rs1];
      src1_tag = rf_tag_q[bus.in_rs1];
    end
    if (bus.in_rs2 != 5'd0) begin
      src2_val = rf_val_q[bus.in_rs2];
      src2_tag = rf_tag_q[bus.in_rs2];
    end
  end

  always_comb begin
    hit1     = cdb_en && (bus.in_CDB_tag == src1_tag);
    hit2     = cdb_en && (bus.in_CDB_tag == src2_tag);
    cap_val1 = hit1 ? bus.in_CDB_val : src1_val;
    cap_tag1 = hit1 ? INVALID_TAG : src1_tag;
    cap_val2 = hit2 ? bus.in_CDB_val : src2_val;
    cap_tag2 = hit2 ? INVALID_TAG : src2_tag;
    if (bus.in_use_imm) begin
      cap_val2 = bus.in_imm;
      cap_tag2 = INVALID_TAG;
    end
  end

  always_comb begin
    icc_hit   = cdb_en && (bus.in_CDB_tag == icc_tag_q);
    icc_ready = (icc_tag_q == INVALID_TAG) || icc_hit;
    cap_flags = icc_hit ? bus.in_CDB_ICC_flags : icc_val_q;
  end

  assign carry_stall = (state_q == IDLE) && bus.in_instr_valid &&
                       bus.in_operator_type[3] && !icc_ready;
  assign capture     = (state_q == IDLE) && bus.in_instr_valid && !carry_stall;
  assign ack_fire    = (state_q == WAIT_ACK) && bus.in_rs_ack;
  assign icc_rename  = ack_fire && op_q[4];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (capture) state_d = SEND;
      SEND:     state_d = WAIT_ACK;
      WAIT_ACK: if (bus.in_rs_ack) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    stall_d = stall_q;
    if (((state_q == WAIT_ACK) || carry_stall) && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  // r0 is neither renamed nor written back.
  always_comb begin
    ren_hit = '0;
    wb_hit  = '0;
    for (int i = 1; i < 32; i++) begin
      ren_hit[i] = ack_fire && (rd_q == 5'(i));
      wb_hit[i]  = cdb_en && (rf_tag_q[i] == bus.in_CDB_tag);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rf_val_q[i] <= '0;
        rf_tag_q[i] <= INVALID_TAG;
      end
      icc_val_q <= '0;
      icc_tag_q <= INVALID_TAG;
    end else begin
      // A rename beats a same-cycle write-back: new tag, value left alone.
      for (int i = 0; i < 32; i++) begin
        if (ren_hit[i]) begin
          rf_tag_q[i] <= bus.in_rs_tag;
        end else if (wb_hit[i]) begin
          rf_val_q[i] <= bus.in_CDB_val;
          rf_tag_q[i] <= INVALID_TAG;
        end
      end
      if (icc_rename) begin
        icc_tag_q <= bus.in_rs_tag;
      end else if (icc_hit) begin
        icc_val_q <= bus.in_CDB_ICC_flags;
        icc_tag_q <= INVALID_TAG;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      val1_q  <= '0;
      val2_q  <= '0;
      tag1_q  <= INVALID_TAG;
      tag2_q  <= INVALID_TAG;
      flags_q <= '0;
      rd_q    <= '0;
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
      if (capture) begin
        op_q    <= bus.in_operator_type;
        val1_q  <= cap_val1;
        val2_q  <= cap_val2;
        tag1_q  <= cap_tag1;
        tag2_q  <= cap_tag2;
        flags_q <= cap_flags;
        rd_q    <= bus.in_rd;
      end
    end
  end

  assign bus.out_instr_ready   = !rst && (state_q == IDLE) && !carry_stall;
  assign bus.out_rs_enable     = (state_q == SEND);
  assign bus.out_operator_type = op_q;
  assign bus.out_val_1         = val1_q;
  assign bus.out_val_2         = val2_q;
  assign bus.out_tag_1         = tag1_q;
  assign bus.out_tag_2         = tag2_q;
  assign bus.out_ICC_flags     = flags_q;
  assign bus.out_stall_cycles  = stall_q;

endmodule

// File: tb/tb_issue_unit.sv
// Self-checking bench for issue_unit: directed scenarios plus randomized
// instruction streams against a transaction-level register/ICC model.
module tb_issue_unit;
  localparam logic [4:0] INV = 5'h1F;

  logic clk;
  logic rst;
  int   vecs;
  int   errs;

  issue_if bus ();
  issue_unit dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: architectural register values and pending tags
  logic [31:0] m_val [32];
  logic [4:0]  m_tag [32];
  logic [3:0]  m_icc;
  logic [4:0]  m_icc_tag;
  int          exp_stall;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_instr_valid   = 1'b0;
    bus.in_operator_type = '0;
    bus.in_rs1           = '0;
    bus.in_rs2           = '0;
    bus.in_rd            = '0;
    bus.in_use_imm       = 1'b0;
    bus.in_imm           = '0;
    bus.in_rs_ack        = 1'b0;
    bus.in_rs_tag        = '0;
    bus.in_CDB_broadcast = 1'b0;
    bus.in_CDB_tag       = INV;
    bus.in_CDB_val       = '0;
    bus.in_CDB_ICC_flags = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic use_imm, input logic [31:0] imm);
    bus.in_instr_valid   = 1'b1;
    bus.in_operator_type = op;
    bus.in_rs1           = rs1;
    bus.in_rs2           = rs2;
    bus.in_rd            = rd;
    bus.in_use_imm       = use_imm;
    bus.in_imm           = imm;
  endtask

  task automatic set_cdb(input logic b, input logic [4:0] t, input logic [31:0] v,
                         input logic [3:0] f);
    bus.in_CDB_broadcast = b;
    bus.in_CDB_tag       = t;
    bus.in_CDB_val       = v;
    bus.in_CDB_ICC_flags = f;
  endtask

  task automatic ack_now(input logic [4:0] t);
    bus.in_rs_ack = 1'b1;
    bus.in_rs_tag = t;
    tick();
    bus.in_rs_ack = 1'b0;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0;
      m_tag[i] = INV;
    end
    m_icc     = '0;
    m_icc_tag = INV;
    exp_stall = 0;
  endfunction

  function automatic void model_read(input logic [4:0] r, input logic b, input logic [4:0] ct,
                                     input logic [31:0] cv, output logic [31:0] v,
                                     output logic [4:0] t);
    if (r == 5'd0) begin
      v = '0;
      t = INV;
    end else if (b && ct != INV && ct == m_tag[r]) begin
      v = cv;
      t = INV;
    end else begin
      v = m_val[r];
      t = m_tag[r];
    end
  endfunction

  // Broadcast results; the register/ICC being renamed this cycle keeps its value.
  function automatic void model_cdb(input logic b, input logic [4:0] ct, input logic [31:0] cv,
                                    input logic [3:0] cf, input logic [4:0] skip_r,
                                    input logic skip_icc);
    if (!b || ct == INV) return;
    for (int i = 1; i < 32; i++)
      if (m_tag[i] == ct && !(skip_r != 5'd0 && 5'(i) == skip_r)) begin
        m_val[i] = cv;
        m_tag[i] = INV;
      end
    if (m_icc_tag == ct && !skip_icc) begin
      m_icc     = cf;
      m_icc_tag = INV;
    end
  endfunction

  task automatic rand_cdb(output logic b, output logic [4:0] ct, output logic [31:0] cv,
                          output logic [3:0] cf);
    int sel;
    b   = 1'($urandom_range(0, 1));
    sel = $urandom_range(0, 3);
    if (sel == 0)      ct = 5'($urandom_range(0, 31));
    else if (sel == 3) ct = m_icc_tag;
    else               ct = m_tag[$urandom_range(1, 31)];
    cv = $urandom;
    cf = 4'($urandom_range(0, 15));
    set_cdb(b, ct, cv, cf);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #3;
    vecs++;
    if ({bus.out_instr_ready, bus.out_rs_enable, bus.out_val_1, bus.out_val_2, bus.out_tag_1,
         bus.out_tag_2, bus.out_ICC_flags, bus.out_operator_type, bus.out_stall_cycles} !==
        {1'b0, 1'b0, 32'h0, 32'h0, INV, INV, 4'h0, 6'h0, 16'h0}) begin
      errs++;
      $display("FAIL reset_outputs: rdy=%b en=%b v1=%h v2=%h t1=%h t2=%h f=%h op=%h st=%0d, want 0 0 0 0 1f 1f 0 0 0",
               bus.out_instr_ready, bus.out_rs_enable, bus.out_val_1, bus.out_val_2, bus.out_tag_1,
               bus.out_tag_2, bus.out_ICC_flags, bus.out_operator_type, bus.out_stall_cycles);
    end
    tick();
    rst = 1'b0;
    #1;
    vecs++;
    if (bus.out_instr_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_release_ready: got %b want 1", bus.out_instr_ready);
    end
  endtask

  task automatic test_add();
    issue(6'h01, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0);
    #1;
    vecs++;
    if (bus.out_instr_ready !== 1'b1) begin
      errs++;
      $display("FAIL add_ready: got %b want 1", bus.out_instr_ready);
    end
    tick();
    bus.in_instr_valid = 1'b0;
    vecs++;
    if ({bus.out_rs_enable, bus.out_val_1, bus.out_val_2, bus.out_tag_1, bus.out_tag_2} !==
        {1'b1, 32'h0, 32'h0, INV, INV}) begin
      errs++;
      $display("FAIL add_dispatch: en=%b v1=%h v2=%h t1=%h t2=%h want 1 0 0 1f 1f",
               bus.out_rs_enable, bus.out_val_1, bus.out_val_2, bus.out_tag_1, bus.out_tag_2);
    end
    tick();
    vecs++;
    if (bus.out_rs_enable !== 1'b0) begin
      errs++;
      $display("FAIL add_strobe_width: en=%b want 0 in WAIT_ACK", bus.out_rs_enable);
    end
    ack_now(5'd8);
  endtask

  task automatic test_sub_imm();
    issue(6'h02, 5'd3, 5'd0, 5'd4, 1'b1, 32'd5);
    tick();
    bus.in_instr_valid = 1'b0;
    vecs++;
    if ({bus.out_rs_enable, bus.out_tag_1, bus.out_val_2, bus.out_tag_2} !==
        {1'b1, 5'd8, 32'd5, INV}) begin
      errs++;
      $display("FAIL sub_imm: en=%b t1=%h v2=%h t2=%h want 1 08 5 1f",
               bus.out_rs_enable, bus.out_tag_1, bus.out_val_2, bus.out_tag_2);
    end
    tick();
    ack_now(5'd12);
  endtask

  task automatic test_cdb_bypass();
    issue(6'h01, 5'd3, 5'd4, 5'd0, 1'b0, 32'h0);
    set_cdb(1'b1, 5'd8, 32'h10, 4'h0);
    tick();
    bus.in_instr_valid = 1'b0;
    set_cdb(1'b0, INV, 32'h0, 4'h0);
    vecs++;
    if ({bus.out_val_1, bus.out_tag_1, bus.out_tag_2} !== {32'h10, INV, 5'd12}) begin
      errs++;
      $display("FAIL cdb_bypass: v1=%h t1=%h t2=%h want 10 1f 0c",
               bus.out_val_1, bus.out_tag_1, bus.out_tag_2);
    end
    tick();
    ack_now(5'd13);
    issue(6'h01, 5'd3, 5'd0, 5'd0, 1'b0, 32'h0);
    tick();
    bus.in_instr_valid = 1'b0;
    vecs++;
    if ({bus.out_val_1, bus.out_tag_1} !== {32'h10, INV}) begin
      errs++;
      $display("FAIL cdb_writeback_r3: v1=%h t1=%h want 10 1f", bus.out_val_1, bus.out_tag_1);
    end
    tick();
    ack_now(5'd14);
  endtask

  task automatic test_carry_stall();
    issue(6'b010000, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    tick();
    bus.in_instr_valid = 1'b0;
    tick();
    ack_now(5'd9);
    issue(6'b001000, 5'd1, 5'd2, 5'd7, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++;
      if ({bus.out_instr_ready, bus.out_rs_enable} !== 2'b00) begin
        errs++;
        $display("FAIL carry_stall[%0d]: rdy=%b en=%b want 0 0", i, bus.out_instr_ready,
                 bus.out_rs_enable);
      end
      tick();
    end
    set_cdb(1'b1, 5'd9, 32'h0, 4'b1000);
    #1;
    vecs++;
    if (bus.out_instr_ready !== 1'b1) begin
      errs++;
      $display("FAIL carry_resolve_ready: got %b want 1", bus.out_instr_ready);
    end
    tick();
    bus.in_instr_valid = 1'b0;
    set_cdb(1'b0, INV, 32'h0, 4'h0);
    vecs++;
    if ({bus.out_rs_enable, bus.out_ICC_flags, bus.out_operator_type} !== {1'b1, 4'b1000, 6'b001000}) begin
      errs++;
      $display("FAIL carry_dispatch: en=%b f=%b op=%h want 1 1000 08", bus.out_rs_enable,
               bus.out_ICC_flags, bus.out_operator_type);
    end
    tick();
    ack_now(5'd16);
  endtask

  task automatic test_ack_delay();
    int pulses;
    do_reset();
    issue(6'h01, 5'd0, 5'd0, 5'd0, 1'b1, 32'hCAFE0001);
    tick();
    bus.in_instr_valid = 1'b0;
    pulses = 0;
    for (int c = 0; c <= 6; c++) begin
      if (c == 6) begin
        bus.in_rs_ack = 1'b1;
        bus.in_rs_tag = 5'd3;
      end
      #1;
      if (bus.out_rs_enable === 1'b1) pulses++;
      vecs++;
      if ({bus.out_operator_type, bus.out_val_2, bus.out_tag_2} !== {6'h01, 32'hCAFE0001, INV}) begin
        errs++;
        $display("FAIL ack_delay_hold[%0d]: op=%h v2=%h t2=%h want 01 cafe0001 1f", c,
                 bus.out_operator_type, bus.out_val_2, bus.out_tag_2);
      end
      tick();
    end
    bus.in_rs_ack = 1'b0;
    vecs++;
    if (pulses !== 1) begin
      errs++;
      $display("FAIL ack_delay_pulses: got %0d want 1", pulses);
    end
    vecs++;
    if (bus.out_stall_cycles !== 16'd6) begin
      errs++;
      $display("FAIL ack_delay_stall: got %0d want 6", bus.out_stall_cycles);
    end
  endtask

  task automatic test_rename_vs_cdb();
    issue(6'h01, 5'd0, 5'd0, 5'd5, 1'b0, 32'h0);
    tick();
    bus.in_instr_valid = 1'b0;
    tick();
    ack_now(5'd7);
    issue(6'h01, 5'd0, 5'd0, 5'd5, 1'b0, 32'h0);
    tick();
    bus.in_instr_valid = 1'b0;
    tick();
    set_cdb(1'b1, 5'd7, 32'hDEAD_BEEF, 4'h0);
    ack_now(5'd10);
    set_cdb(1'b0, INV, 32'h0, 4'h0);
    issue(6'h01, 5'd5, 5'd0, 5'd0, 1'b0, 32'h0);
    tick();
    bus.in_instr_valid = 1'b0;
    vecs++;
    if ({bus.out_tag_1, bus.out_val_1} !== {5'd10, 32'h0}) begin
      errs++;
      $display("FAIL rename_wins: t1=%h v1=%h want 0a 0", bus.out_tag_1, bus.out_val_1);
    end
    tick();
    ack_now(5'd15);
  endtask

  task automatic test_reset_mid();
    issue(6'h01, 5'd0, 5'd0, 5'd6, 1'b0, 32'h0);
    tick();
    bus.in_instr_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    vecs++;
    if ({bus.out_rs_enable, bus.out_instr_ready, bus.out_tag_1} !== {1'b0, 1'b0, INV}) begin
      errs++;
      $display("FAIL reset_mid: en=%b rdy=%b t1=%h want 0 0 1f", bus.out_rs_enable,
               bus.out_instr_ready, bus.out_tag_1);
    end
    tick();
    rst = 1'b0;
    ack_now(5'd11);
    issue(6'h01, 5'd6, 5'd5, 5'd0, 1'b0, 32'h0);
    #1;
    vecs++;
    if (bus.out_instr_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_mid_idle: rdy=%b want 1", bus.out_instr_ready);
    end
    tick();
    bus.in_instr_valid = 1'b0;
    vecs++;
    if ({bus.out_rs_enable, bus.out_tag_1, bus.out_tag_2} !== {1'b1, INV, INV}) begin
      errs++;
      $display("FAIL reset_mid_no_rename: en=%b t1=%h t2=%h want 1 1f 1f", bus.out_rs_enable,
               bus.out_tag_1, bus.out_tag_2);
    end
    tick();
    ack_now(5'd2);
  endtask

  task automatic test_random();
    logic [5:0]  op;
    logic [4:0]  rs1, rs2, rd, ct, rt;
    logic        use_imm, b, resolved, stall, captured;
    logic [31:0] imm, cv, e_v1, e_v2;
    logic [4:0]  e_t1, e_t2;
    logic [3:0]  cf, e_f;
    int          k;
    do_reset();
    model_reset();
    e_v1 = '0; e_v2 = '0; e_t1 = INV; e_t2 = INV; e_f = '0;
    for (int n = 0; n < 80; n++) begin
      op      = 6'($urandom_range(0, 63));
      rs1     = 5'($urandom_range(0, 31));
      rs2     = 5'($urandom_range(0, 31));
      rd      = 5'($urandom_range(0, 31));
      use_imm = 1'($urandom_range(0, 1));
      imm     = $urandom;
      rt      = 5'($urandom_range(0, 30));
      issue(op, rs1, rs2, rd, use_imm, imm);
      captured = 1'b0;
      for (int c = 0; c < 8 && !captured; c++) begin
        rand_cdb(b, ct, cv, cf);
        if (c >= 4 && op[3] && m_icc_tag != INV) begin
          b  = 1'b1;
          ct = m_icc_tag;
          set_cdb(b, ct, cv, cf);
        end
        bus.in_rs_ack = 1'($urandom_range(0, 1));
        bus.in_rs_tag = 5'($urandom_range(0, 30));
        resolved = (m_icc_tag == INV) || (b && ct != INV && ct == m_icc_tag);
        stall    = op[3] && !resolved;
        #1;
        vecs++;
        if (bus.out_instr_ready !== !stall) begin
          errs++;
          $display("FAIL rand_ready[%0d]: got %b want %b", n, bus.out_instr_ready, !stall);
        end
        if (stall) begin
          exp_stall++;
        end else begin
          model_read(rs1, b, ct, cv, e_v1, e_t1);
          if (use_imm) begin
            e_v2 = imm;
            e_t2 = INV;
          end else begin
            model_read(rs2, b, ct, cv, e_v2, e_t2);
          end
          e_f = (b && ct != INV && ct == m_icc_tag) ? cf : m_icc;
          captured = 1'b1;
        end
        model_cdb(b, ct, cv, cf, 5'd0, 1'b0);
        tick();
      end
      bus.in_instr_valid = 1'b0;
      bus.in_rs_ack      = 1'b0;
      k = $urandom_range(1, 3);
      for (int w = 0; w <= k; w++) begin
        rand_cdb(b, ct, cv, cf);
        if (w == k) begin
          bus.in_rs_ack = 1'b1;
          bus.in_rs_tag = rt;
        end
        #1;
        vecs++;
        if ({bus.out_rs_enable, bus.out_operator_type, bus.out_val_1, bus.out_tag_1, bus.out_val_2,
             bus.out_tag_2, bus.out_ICC_flags} !== {(w == 0), op, e_v1, e_t1, e_v2, e_t2, e_f}) begin
          errs++;
          $display("FAIL rand_dispatch[%0d.%0d]: en=%b op=%h v1=%h t1=%h v2=%h t2=%h f=%h want %b %h %h %h %h %h %h",
                   n, w, bus.out_rs_enable, bus.out_operator_type, bus.out_val_1, bus.out_tag_1,
                   bus.out_val_2, bus.out_tag_2, bus.out_ICC_flags, (w == 0), op, e_v1, e_t1,
                   e_v2, e_t2, e_f);
        end
        if (w == k) begin
          model_cdb(b, ct, cv, cf, rd, op[4]);
          if (rd != 5'd0) m_tag[rd] = rt;
          if (op[4]) m_icc_tag = rt;
        end else begin
          model_cdb(b, ct, cv, cf, 5'd0, 1'b0);
        end
        if (w > 0) exp_stall++;
        tick();
      end
      bus.in_rs_ack = 1'b0;
      set_cdb(1'b0, INV, 32'h0, 4'h0);
    end
    vecs++;
    if (bus.out_stall_cycles !== 16'(exp_stall)) begin
      errs++;
      $display("FAIL rand_stall_count: got %0d want %0d", bus.out_stall_cycles, exp_stall);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst  = 1'b0;
    idle_inputs();
    test_reset();
    test_add();
    test_sub_imm();
    test_cdb_bypass();
    test_carry_stall();
    test_ack_delay();
    test_rename_vs_cdb();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
